pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the address width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address-stack entries (power of two, at least 2).
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port fetch_ready_in, input, 1 bit: fetch stage accepts pc_out this cycle.
REQ-007 The block SHALL have port stall_in, input, 1 bit: pipeline stall; hold the PC.
REQ-008 The block SHALL have port redirect_valid_in, input, 1 bit: branch/jump resolved taken.
REQ-009 The block SHALL have port redirect_addr_in, input, XLEN bits: redirect target.
REQ-010 The block SHALL have port ras_push_in, input, 1 bit: current instruction is a call.
REQ-011 The block SHALL have port ras_pop_in, input, 1 bit: current instruction is a return.
REQ-012 The block SHALL have port pc_out, output, XLEN bits: current fetch address.
REQ-013 The block SHALL have port pc_valid_out, output, 1 bit: pc_out is valid for fetch.
REQ-014 The block SHALL have port misaligned_out, output, 1 bit: one-cycle pulse flagging a rejected redirect.

Function
REQ-015 The FSM SHALL have two states: BOOT (pc_valid_out=0) and RUN (pc_valid_out=1); BOOT SHALL go to RUN after exactly one cycle, and RUN SHALL persist until reset.
REQ-016 An advance SHALL occur when state=RUN, fetch_ready_in=1 and stall_in=0.
REQ-017 Next-PC priority SHALL be: accepted redirect, then RAS pop with non-empty stack on advance, then pc_out+4 on advance, else hold.
REQ-018 A redirect SHALL take effect on the next edge regardless of stall_in, fetch_ready_in or state, with 1-cycle latency.
REQ-019 A redirect with redirect_addr_in[1:0]!=0 SHALL be rejected: PC unchanged, misaligned_out=1 for one cycle, and lower-priority sources SHALL still apply that cycle.
REQ-020 Sequential increment SHALL wrap modulo 2^XLEN, e.g. all-ones-minus-3 plus 4 gives 0.
REQ-021 ras_push_in and ras_pop_in SHALL be honoured only on an advance cycle with no accepted redirect; otherwise the RAS SHALL be unchanged.
REQ-022 A push SHALL store pc_out+4 at the top, and count SHALL saturate at RAS_DEPTH; a push when full SHALL overwrite the oldest entry (circular pointer).
REQ-023 A pop SHALL take the top entry as the next PC and decrement count; a pop when empty SHALL fall back to pc_out+4 and leave count at 0.
REQ-024 A simultaneous push and pop SHALL set the next PC to the old top and replace the top with pc_out+4, leaving count unchanged.
REQ-025 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-026 While reset=1: pc_out=RESET_VECTOR, pc_valid_out=0, misaligned_out=0, state=BOOT, RAS count=0 and pointer=0.
REQ-027 Reset asserted mid-operation SHALL override every other input on the same edge, including a redirect and a push or pop.
REQ-028 RAS entry contents need not be cleared on reset, but the count SHALL be zero.

Structure
REQ-029 Shared package pc_pkg SHALL hold the state enum (BOOT, RUN) and the constant INSTR_BYTES=4.
REQ-030 The RAS SHALL be a separate sub-module ras_stack parametrised by XLEN and RAS_DEPTH, with push, pop, top and empty ports.

Verification
REQ-031 Reset release with fetch_ready_in=1 -> one cycle at pc_valid_out=0, then pc_out sequence 0, 4, 8, 12.
REQ-032 stall_in=1 for 3 cycles at pc_out=0x10 -> pc_out stays 0x10; redirect to 0x200 during the stall -> next cycle pc_out=0x200.
REQ-033 Redirect to 0x202 -> misaligned_out pulses once and the PC advances sequentially as if no redirect.
REQ-034 Push at pc 0x100 and again at pc 0x300, then pop twice -> targets 0x304 then 0x104; a third pop falls back to pc_out+4.
REQ-035 RAS_DEPTH+1 pushes then RAS_DEPTH+1 pops -> first RAS_DEPTH targets in LIFO order with the oldest lost; the last pop is sequential.
REQ-036 With pc_out=2^XLEN-4, advance -> pc_out=0; reset asserted together with a redirect -> pc_out=RESET_VECTOR and pc_valid_out=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and the fixed
// instruction size used for sequential fetch.
package pc_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned INSTR_BYTES = 32'd4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a combined push/pop replaces the top entry in place.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] top_idx_s;
  logic             replace_s;
  logic             push_only_s;
  logic             pop_only_s;

  // ptr_r is the next free slot; the top lives one below it
  assign top_idx_s   = ptr_r - PTR_W'(1);
  assign top         = mem_r[top_idx_s];
  assign empty       = (count_r == CNT_W'(0));
  assign replace_s   = push && pop && !empty;
  assign push_only_s = push && !replace_s;
  assign pop_only_s  = pop && !push && !empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk_in) begin
    if (reset) begin
      ptr_r   <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else if (push_only_s) begin
      ptr_r   <= ptr_r + PTR_W'(1);
      count_r <= (count_r == CNT_W'(RAS_DEPTH)) ? count_r : count_r + CNT_W'(1);
    end else if (pop_only_s) begin
      ptr_r   <= ptr_r - PTR_W'(1);
      count_r <= count_r - CNT_W'(1);
    end else begin
      ptr_r   <= ptr_r;
      count_r <= count_r;
    end
  end

  // Entry storage; contents are don't-care after reset since count gates use
  always_ff @(posedge clk_in) begin
    if (replace_s) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push_only_s) begin
      mem_r[ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot/run FSM, aligned redirects, sequential advance and
// return-address prediction through ras_stack. All outputs come from flops.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            fetch_ready_in,
  input  logic            stall_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_addr_in,
  input  logic            ras_push_in,
  input  logic            ras_pop_in,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid_out,
  output logic            misaligned_out
);

  pc_state_e       state_r;
  pc_state_e       state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] seq_pc_s;
  logic            valid_r;
  logic            misaligned_r;
  logic            advance_s;
  logic            misaligned_s;
  logic            redirect_ok_s;
  logic            ras_push_s;
  logic            ras_pop_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_empty_s;

  assign advance_s     = (state_r == RUN) && fetch_ready_in && !stall_in;
  assign misaligned_s  = redirect_valid_in && (redirect_addr_in[1:0] != 2'b00);
  assign redirect_ok_s = redirect_valid_in && (redirect_addr_in[1:0] == 2'b00);
  assign seq_pc_s      = pc_r + XLEN'(INSTR_BYTES);
  // A rejected redirect leaves the RAS operations of this cycle intact
  assign ras_push_s    = advance_s && !redirect_ok_s && ras_push_in;
  assign ras_pop_s     = advance_s && !redirect_ok_s && ras_pop_in;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (seq_pc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      BOOT:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = BOOT;
    endcase
    if (redirect_ok_s) begin
      pc_next_s = redirect_addr_in;
    end else if (ras_pop_s && !ras_empty_s) begin
      pc_next_s = ras_top_s;
    end else if (advance_s) begin
      pc_next_s = seq_pc_s;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pc_r         <= RESET_VECTOR;
      valid_r      <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      pc_r         <= pc_next_s;
      valid_r      <= (state_next_s == RUN);
      misaligned_r <= misaligned_s;
    end
  end

  assign pc_out         = pc_r;
  assign pc_valid_out   = valid_r;
  assign misaligned_out = misaligned_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ready_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid_in = 1'b0;
  logic [63:0] redirect_addr_in = 64'd0;
  logic        ras_push_in = 1'b0;
  logic        ras_pop_in = 1'b0;
  logic [63:0] pc_out;
  logic        pc_valid_out;
  logic        misaligned_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc = 64'd0;
  bit          m_valid = 1'b0;
  bit          m_mis = 1'b0;
  logic [63:0] m_ras[$];

  always #5 clk_in = ~clk_in;

  pc_sequencer #(
    .XLEN         (64),
    .RESET_VECTOR (64'd0),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .fetch_ready_in    (fetch_ready_in),
    .stall_in          (stall_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_addr_in  (redirect_addr_in),
    .ras_push_in       (ras_push_in),
    .ras_pop_in        (ras_pop_in),
    .pc_out            (pc_out),
    .pc_valid_out      (pc_valid_out),
    .misaligned_out    (misaligned_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, then compare.
  task automatic cycle(input bit rst, input bit rdy, input bit stl, input bit rv,
                       input logic [63:0] ra, input bit psh, input bit pp);
    bit          adv, acc;
    logic [63:0] seq, npc;
    reset = rst; fetch_ready_in = rdy; stall_in = stl;
    redirect_valid_in = rv; redirect_addr_in = ra;
    ras_push_in = psh; ras_pop_in = pp;
    if (rst) begin
      npc = 64'd0; m_valid = 1'b0; m_mis = 1'b0; m_ras.delete();
    end else begin
      adv   = m_valid && rdy && !stl;
      m_mis = rv && (ra % 64'd4 != 64'd0);
      acc   = rv && !m_mis;
      seq   = m_pc + 64'd4;
      npc   = m_pc;
      if (acc) begin
        npc = ra;
      end else if (adv) begin
        if (pp && m_ras.size() > 0) begin
          npc = m_ras[$];
          if (psh) m_ras[m_ras.size()-1] = seq;
          else void'(m_ras.pop_back());
        end else begin
          npc = seq;
          if (psh) begin
            if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(seq);
          end
        end
      end
      m_valid = 1'b1;
    end
    m_pc = npc;
    @(posedge clk_in);
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("pc_valid_out", {63'd0, pc_valid_out}, {63'd0, m_valid});
    chk("misaligned_out", {63'd0, misaligned_out}, {63'd0, m_mis});
  endtask

  initial begin
    // reset, then release with fetch ready: one invalid cycle, then 0,4,8,12
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("reset_pc", pc_out, 64'd0);
    chk("reset_valid", {63'd0, pc_valid_out}, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("boot_pc", pc_out, 64'd0);
    chk("boot_valid", {63'd0, pc_valid_out}, 64'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("seq_4", pc_out, 64'd4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("seq_8", pc_out, 64'd8);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("seq_12", pc_out, 64'd12);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);

    // stall holds 0x10; redirect during stall lands next cycle
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
      chk("stall_hold", pc_out, 64'h10);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 64'h200, 1'b0, 1'b0);
    chk("stall_redirect", pc_out, 64'h200);

    // misaligned redirect: one pulse, sequential advance
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h202, 1'b0, 1'b0);
    chk("mis_pulse", {63'd0, misaligned_out}, 64'd1);
    chk("mis_pc", pc_out, 64'h204);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("mis_clear", {63'd0, misaligned_out}, 64'd0);

    // calls at 0x100 and 0x300, then three returns
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h100, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h300, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("ret_1", pc_out, 64'h304);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("ret_2", pc_out, 64'h104);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("ret_empty", pc_out, 64'h108);

    // overflow: DEPTH+1 pushes then DEPTH+1 pops
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // push+pop together, pop during stall, then drain
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // wrap at the top of the address space
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("wrap", pc_out, 64'd0);

    // reset beats a same-edge redirect and push; stack is empty afterwards
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 64'h400, 1'b1, 1'b0);
    chk("rst_redirect_pc", pc_out, 64'd0);
    chk("rst_redirect_valid", {63'd0, pc_valid_out}, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("rst_pop_seq", pc_out, 64'd4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] ra;
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), ra,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
